bitstream_packer: RTL and testbench
===================================

// Module: bitstream_packer
// PURPOSE
//  Sits directly downstream of the Golomb/exp-Golomb codeword stage in the entropy coder.
//  Accepts variable-length codewords (value + bit length) and packs them MSB-first into
//  a continuous bitstream. Emits fixed-width words over a valid/ready interface.
//  On flush, zero-pads the tail to a word boundary and marks the final word.
// PARAMETERS
//  WORD_W  32  output word width; 16 and 32 are supported
//  LEN_W   6   code_len width, equal to $clog2(WORD_W)+1
// PORTS
//  clk         in   1       clock, all logic on posedge
//  reset_n     in   1       asynchronous, active-low reset
//  in_valid    in   1       codeword present
//  in_ready    out  1       packer accepts codeword/flush this cycle
//  code        in   WORD_W  codeword, right-aligned; bits at or above code_len are ignored
//  code_len    in   LEN_W   codeword length 0..WORD_W; values above WORD_W are clamped to WORD_W
//  flush       in   1       end of slice; qualified by in_ready (in_valid not required)
//  out_valid   out  1       out_word valid
//  out_ready   in   1       downstream accepts out_word
//  out_word    out  WORD_W  packed bits; first-received bit is at the MSB
//  out_last    out  1       final word of a flush; valid with out_valid
//  flush_done  out  1       one-cycle pulse when flush is complete
//  total_bits  out  32      only present with PACKER_BIT_COUNT_EN
// BEHAVIOUR
//  - Reset values: in_ready=0 during reset, out_valid=0, out_word=0, out_last=0, flush_done=0.
//    Internal 2*WORD_W-bit accumulator acc=0, fill=0, state=RUN.
//  - Reset is honoured mid-operation: all pending bits are discarded and no partial word is emitted.
//  - State machine has three states: RUN, DRAIN, DONE.
//  - Accept condition: accept = in_valid & in_ready.
//    in_ready = (state==RUN) & (fill<WORD_W | ~out_valid | out_ready).
//  - Emit condition: emit = (fill>=WORD_W) & (~out_valid | out_ready).
//    On emit, at the edge: out_word <= acc[top WORD_W], acc shifts left by WORD_W, fill -= WORD_W.
//  - Emit and accept may occur in the same cycle:
//    * the shift is applied first;
//    * the masked code is then placed at bit positions [2W-1-fill' -: len];
//    * fill'' = fill' + len.
//    The maximum fill is 2W-1, so the accumulator never overflows.
//  - Latency: a word completed at edge N is presented with out_valid=1 after edge N+1.
//    Sustained throughput is 1 codeword/cycle, including back-to-back WORD_W-length codes.
//  - Backpressure: out_valid and out_word stay stable while out_ready=0.
//    in_ready drops once fill>=WORD_W and the output register is held.
//  - code_len=0 is accepted as a no-op; fill is unchanged.
//  - Flush in RUN (in_ready=1): if in_valid is also high, the code is accepted first; then state goes to DRAIN.
//  - DRAIN:
//    * emits full words as normal;
//    * when 0<fill<WORD_W and the output is free, emits acc top bits with the tail zero-padded,
//      out_last=1, fill=0, then goes to DONE;
//    * if fill reaches exactly 0 after a full word, that word is flagged out_last=1;
//    * if fill==0 when flush is taken, no word is emitted and state goes to DONE.
//  - DONE: waits until any out_last word has handshaken, then pulses flush_done for 1 cycle
//    and returns to RUN. in_ready=0 for the whole flush sequence.
//  - out_last is cleared on the handshake of its word.
// CONFIGURATION
//  PACKER_BIT_COUNT_EN defined:
//   - Port total_bits is present. It counts accepted code bits (after clamping), excluding padding.
//   - Cleared by reset and by the flush_done pulse; wraps modulo 2^32.
//  PACKER_BIT_COUNT_EN undefined:
//   - Port and counter are absent. All other behaviour is identical.
// TESTING
//  1. Send 11 codes of 3'b101 (len=3), out_ready=1, then flush.
//     -> out_word 0xB6DB6DB6, then 0x80000000 with out_last=1, then a flush_done pulse.
//  2. Send 0xDEADBEEF (len 32) and 0x12345678 (len 32) back-to-back.
//     -> in_ready stays 1; words appear on consecutive cycles.
//  3. Hold out_ready=0 for 5 cycles with codes pending.
//     -> out_word is held stable; in_ready=0 once fill>=32; no bits are lost after release.
//  4. Flush with fill=0.
//     -> no out_valid; flush_done pulses once, 1 cycle later; in_ready returns to 1.
//  5. Send code 0xFFFFFFFF with len=4, then flush.
//     -> out_word 0xF0000000, out_last=1. Also send len=40: it is treated as 32.
//  6. Drop reset_n with fill=20 and out_valid=1.
//     -> out_valid=0 immediately; after release, the next flush emits no word.

Source files
------------

// File: rtl/bitstream_packer_if.sv
// Handshake bundle for bitstream_packer: codeword input side and packed-word output side.
// Optional feature macro: PACKER_BIT_COUNT_EN adds the total_bits counter output.
interface bitstream_packer_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] code;
    logic [LEN_W-1:0]  code_len;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_last;
    logic              flush_done;
`ifdef PACKER_BIT_COUNT_EN
    logic [31:0]       total_bits;

    modport master (
        output in_valid, code, code_len, flush, out_ready,
        input  in_ready, out_valid, out_word, out_last, flush_done, total_bits
    );

    modport slave (
        input  in_valid, code, code_len, flush, out_ready,
        output in_ready, out_valid, out_word, out_last, flush_done, total_bits
    );
`else
    modport master (
        output in_valid, code, code_len, flush, out_ready,
        input  in_ready, out_valid, out_word, out_last, flush_done
    );

    modport slave (
        input  in_valid, code, code_len, flush, out_ready,
        output in_ready, out_valid, out_word, out_last, flush_done
    );
`endif
endinterface

// File: rtl/bitstream_packer.sv
// Packs variable-length codewords MSB-first into fixed WORD_W-bit words.
// A flush zero-pads the tail to a word boundary, flags the final word and pulses flush_done.
// Optional feature macro: PACKER_BIT_COUNT_EN adds a running count of accepted code bits.
module bitstream_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input logic               clk,
    input logic               reset_n,
    bitstream_packer_if.slave bus
);
    localparam int unsigned      ACC_W  = 2 * WORD_W;
    localparam logic [LEN_W-1:0] WORD_L = LEN_W'(WORD_W);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ACC_W-1:0]  acc_q, acc_shift, acc_d, placed;
    logic [LEN_W-1:0]  fill_q, fill_shift, fill_d, len_c, len_eff;
    logic [WORD_W-1:0] code_mask;
    logic              out_free, emit_full, emit_tail, accept, take_flush, in_ready, done_now;

    // Handshake decode and accumulator next-state: shift out a full word first, then append.
    always_comb begin
        out_free   = ~bus.out_valid | bus.out_ready;
        in_ready   = reset_n && (state_q == StRun) && ((fill_q < WORD_L) || out_free);
        accept     = bus.in_valid & in_ready;
        take_flush = bus.flush & in_ready;
        emit_full  = (fill_q >= WORD_L) && out_free && (state_q != StDone);
        emit_tail  = (state_q == StDrain) && (fill_q != '0) && (fill_q < WORD_L) && out_free;
        done_now   = (state_q == StDone) && !(bus.out_valid && bus.out_last);

        len_c      = (bus.code_len > WORD_L) ? WORD_L : bus.code_len;
        len_eff    = accept ? len_c : '0;
        code_mask  = (len_c == WORD_L) ? '1 : ((WORD_W'(1) << len_c) - WORD_W'(1));

        acc_shift  = emit_full ? {acc_q[WORD_W-1:0], {WORD_W{1'b0}}} : acc_q;
        fill_shift = emit_full ? (fill_q - WORD_L) : fill_q;
        // Left-justify the code in the upper half, then slide it down behind the valid bits.
        placed     = ({bus.code & code_mask, {WORD_W{1'b0}}} << (WORD_L - len_c)) >> fill_shift;
        acc_d      = accept ? (acc_shift | placed) : acc_shift;
        fill_d     = fill_shift + len_eff;

        bus.in_ready = in_ready;
    end

    // Flush FSM, accumulator and registered output word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StRun;
            acc_q          <= '0;
            fill_q         <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_word   <= '0;
            bus.out_last   <= 1'b0;
            bus.flush_done <= 1'b0;
        end else begin
            bus.flush_done <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            unique case (state_q)
                StRun: begin
                    acc_q  <= acc_d;
                    fill_q <= fill_d;
                    if (emit_full) begin
                        bus.out_word  <= acc_q[ACC_W-1 -: WORD_W];
                        bus.out_valid <= 1'b1;
                        // A word that empties the packer on the flush cycle ends the slice.
                        bus.out_last  <= take_flush && (fill_d == '0);
                    end
                    if (take_flush) begin
                        state_q <= (fill_d == '0) ? StDone : StDrain;
                    end
                end
                StDrain: begin
                    if (emit_full) begin
                        bus.out_word  <= acc_q[ACC_W-1 -: WORD_W];
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= (fill_shift == '0);
                        acc_q         <= acc_shift;
                        fill_q        <= fill_shift;
                        if (fill_shift == '0) begin
                            state_q <= StDone;
                        end
                    end else if (emit_tail) begin
                        // Bits below fill are always zero, so the tail is already padded.
                        bus.out_word  <= acc_q[ACC_W-1 -: WORD_W];
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b1;
                        acc_q         <= '0;
                        fill_q        <= '0;
                        state_q       <= StDone;
                    end else if (fill_q == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (done_now) begin
                        bus.flush_done <= 1'b1;
                        state_q        <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef PACKER_BIT_COUNT_EN
    // Accepted code bits since reset or the last completed flush; padding is not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.total_bits <= '0;
        end else if (done_now) begin
            bus.total_bits <= '0;
        end else if (accept) begin
            bus.total_bits <= bus.total_bits + 32'(len_c);
        end
    end
`endif

endmodule

// File: tb/tb_bitstream_packer.sv
// Self-checking bench for bitstream_packer: table-driven flush scenarios plus hand-written
// sequences for back-to-back codes, backpressure, empty flush and mid-stream reset.
module tb_bitstream_packer;
    typedef struct {
        logic [31:0] code;
        logic [5:0]  len;
        int          reps;
        int          nexp;
        logic [31:0] w0;
        logic        l0;
        logic [31:0] w1;
        logic        l1;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic        last;
        int          cyc;
    } got_t;

    logic clk = 1'b0;
    logic reset_n;

    bitstream_packer_if #(.WORD_W(32), .LEN_W(6)) bus ();

    bitstream_packer #(.WORD_W(32), .LEN_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;
    int   last_waits = 0;
    int   m_total = 0;
    bit   mbits[$];
    exp_t sb_q[$];
    got_t got_q[$];
    vec_t vecs[5];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: a plain bit queue, words cut every 32 bits, tail padded on flush.
    task automatic model_accept(input logic [31:0] c, input logic [5:0] l, input logic f,
                                input logic v);
        int          len;
        logic [31:0] w;
        if (v) begin
            len = (l > 6'd32) ? 32 : int'(l);
            for (int i = len - 1; i >= 0; i--) mbits.push_back(c[i]);
            m_total += len;
            while (mbits.size() >= 32) begin
                w = '0;
                for (int i = 0; i < 32; i++) w = {w[30:0], mbits.pop_front()};
                sb_q.push_back('{w, 1'b0});
            end
        end
        if (f) begin
            m_total = 0;
            if (mbits.size() > 0) begin
                w = '0;
                for (int i = 0; i < 32; i++) begin
                    w = {w[30:0], (mbits.size() > 0) ? mbits.pop_front() : 1'b0};
                end
                sb_q.push_back('{w, 1'b1});
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n && bus.flush_done) done_cnt++;
            if (reset_n && bus.out_valid && bus.out_ready) begin
                got_q.push_back('{bus.out_word, bus.out_last, cyc});
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got %h last %b, expected no word",
                             bus.out_word, bus.out_last);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_word", bus.out_word, e.word);
                    check("sb_last", bus.out_last, e.last);
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f,
                        input logic v);
        bus.in_valid = v;
        bus.code     = c;
        bus.code_len = l;
        bus.flush    = f;
        last_waits   = 0;
        @(negedge clk);
        while (!bus.in_ready && last_waits < 200) begin
            @(negedge clk);
            last_waits++;
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready 0 after %0d cycles, required 1", last_waits);
        end else begin
            model_accept(c, l, f, v);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, done_cnt != start, 1'b1);
    endtask

    initial begin
        vecs[0] = '{32'h5,        6'd3,  11, 2, 32'hB6DB6DB6, 1'b0, 32'h80000000, 1'b1};
        vecs[1] = '{32'hFFFFFFFF, 6'd4,  1,  1, 32'hF0000000, 1'b1, 32'h0,        1'b0};
        vecs[2] = '{32'hFFFFFFFF, 6'd40, 1,  1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
        vecs[3] = '{32'hABCDE123, 6'd8,  1,  1, 32'h23000000, 1'b1, 32'h0,        1'b0};
        vecs[4] = '{32'h5,        6'd0,  4,  0, 32'h0,        1'b0, 32'h0,        1'b0};

        bus.in_valid  = 1'b0;
        bus.code      = '0;
        bus.code_len  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_word", bus.out_word, 32'h0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_flush_done", bus.flush_done, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(1);

        // Table-driven flush scenarios.
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            for (int r = 0; r < vecs[v].reps; r++) send(vecs[v].code, vecs[v].len, 1'b0, 1'b1);
            idle(3);
`ifdef PACKER_BIT_COUNT_EN
            check($sformatf("vec%0d_total_bits", v), bus.total_bits, m_total);
`endif
            send(32'h0, 6'd0, 1'b1, 1'b0);
            wait_done($sformatf("vec%0d_flush_done", v));
            idle(2);
            check($sformatf("vec%0d_nwords", v), got_q.size(), vecs[v].nexp);
            if (vecs[v].nexp >= 1 && got_q.size() >= 1) begin
                check($sformatf("vec%0d_w0", v), got_q[0].word, vecs[v].w0);
                check($sformatf("vec%0d_l0", v), got_q[0].last, vecs[v].l0);
            end
            if (vecs[v].nexp >= 2 && got_q.size() >= 2) begin
                check($sformatf("vec%0d_w1", v), got_q[1].word, vecs[v].w1);
                check($sformatf("vec%0d_l1", v), got_q[1].last, vecs[v].l1);
            end
        end

        // Back-to-back full-width codes.
        got_q.delete();
        send(32'hDEADBEEF, 6'd32, 1'b0, 1'b1);
        check("b2b_wait0", last_waits, 0);
        send(32'h12345678, 6'd32, 1'b0, 1'b1);
        check("b2b_wait1", last_waits, 0);
        idle(3);
        check("b2b_nwords", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("b2b_consecutive", got_q[1].cyc - got_q[0].cyc, 1);
            check("b2b_w0", got_q[0].word, 32'hDEADBEEF);
            check("b2b_w1", got_q[1].word, 32'h12345678);
        end
        send(32'h0, 6'd0, 1'b1, 1'b0);
        wait_done("b2b_flush_done");
        idle(2);

        // Backpressure: output held, input stalls once fill reaches a word.
        got_q.delete();
        bus.out_ready = 1'b0;
        send(32'hCAFEF00D, 6'd32, 1'b0, 1'b1);
        send(32'h000ABCDE, 6'd20, 1'b0, 1'b1);
        send(32'h13579BDF, 6'd32, 1'b0, 1'b1);
        fork
            send(32'h2468ACE0, 6'd32, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_hold_word", bus.out_word, 32'hCAFEF00D);
                    check("bp_hold_valid", bus.out_valid, 1'b1);
                    check("bp_in_ready", bus.in_ready, 1'b0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(3);
        send(32'h0, 6'd0, 1'b1, 1'b0);
        wait_done("bp_flush_done");
        idle(2);
        check("bp_nwords", got_q.size(), 4);

        // Empty flush: no word, flush_done exactly one cycle after the flush is taken.
        got_q.delete();
        send(32'h0, 6'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("empty_done_early", bus.flush_done, 1'b0);
        check("empty_no_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check("empty_done_pulse", bus.flush_done, 1'b1);
        check("empty_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        check("empty_done_width", bus.flush_done, 1'b0);
        check("empty_nwords", got_q.size(), 0);
        idle(1);

        // Reset mid-stream with a held word and 20 pending bits.
        got_q.delete();
        bus.out_ready = 1'b0;
        send(32'hFFFFFFFF, 6'd32, 1'b0, 1'b1);
        send(32'h000ABCDE, 6'd20, 1'b0, 1'b1);
        @(negedge clk);
        check("prerst_valid", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_word", bus.out_word, 32'h0);
        sb_q.delete();
        mbits.delete();
        m_total = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(2);
        send(32'h0, 6'd0, 1'b1, 1'b0);
        wait_done("rst_flush_done");
        idle(2);
        check("rst_nwords", got_q.size(), 0);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
